// File: rtl/mem_read_arb_pkg.sv
// Shared types for mem_read_arbiter: FSM state encoding, statistics width and a saturating
// increment helper.
package mem_read_arb_pkg;

  localparam int unsigned STAT_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_GRANT   = 3'd3,
    S_DELIVER = 3'd4
  } arb_state_t;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit at or after the pointer, wrapping
// at NUM_REQ-1 back to 0.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IdxW-1:0]    i_ptr,
  output logic               o_found,
  output logic [IdxW-1:0]    o_idx
);

  always_comb begin
    int unsigned j;
    j       = 0;
    o_found = 1'b0;
    o_idx   = '0;
    // Scan from the farthest offset down so the nearest match is the one left standing.
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      j = (32'(i_ptr) + k - 1) % NUM_REQ;
      if (i_req[IdxW'(j)]) begin
        o_found = 1'b1;
        o_idx   = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one read-only memory port among NUM_REQ cache miss ports.
// Define MEM_READ_ARB_STATS_EN to add saturating grant and wait-cycle counters.
module mem_read_arbiter
  import mem_read_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DWIDTH     = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DWIDTH-1:0]             req_data,
  output logic                          mem_req_valid,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  input  logic                          mem_req_ready,
  input  logic                          mem_rsp_valid,
`ifdef MEM_READ_ARB_STATS_EN
  input  logic [DWIDTH-1:0]             mem_rsp_data,
  output logic [NUM_REQ*STAT_WIDTH-1:0] stat_grants,
  output logic [STAT_WIDTH-1:0]         stat_wait_cycles
`else
  input  logic [DWIDTH-1:0]             mem_rsp_data
`endif
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t            r_state, w_state_d;
  logic [IdxW-1:0]       r_idx, w_idx_d;
  logic [IdxW-1:0]       r_ptr, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
  logic [DWIDTH-1:0]     r_data, w_data_d;

  logic                  w_found;
  logic [IdxW-1:0]       w_pick_idx;
  logic [ADDR_WIDTH-1:0] w_addr [NUM_REQ];
  logic [NUM_REQ-1:0]    w_onehot;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign w_addr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_ptr_d   = r_ptr;
    w_addr_d  = r_addr;
    w_data_d  = r_data;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_idx_d   = w_pick_idx;
          w_addr_d  = w_addr[w_pick_idx];
          w_state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          if (mem_rsp_valid) begin
            w_data_d  = mem_rsp_data;
            w_state_d = S_GRANT;
          end else begin
            w_state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          w_data_d  = mem_rsp_data;
          w_state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // Pointer advances even when the requester dropped and no ready went out.
        w_ptr_d   = (r_idx == IdxW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
        w_state_d = S_DELIVER;
      end
      S_DELIVER: w_state_d = S_IDLE;
      default:   w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_ptr   <= w_ptr_d;
      r_addr  <= w_addr_d;
      r_data  <= w_data_d;
    end
  end

  assign w_onehot      = NUM_REQ'(1) << r_idx;
  assign req_ready     = (r_state == S_GRANT) ? (req_valid & w_onehot) : '0;
  assign req_data      = r_data;
  assign mem_req_valid = (r_state == S_REQ);
  assign mem_req_addr  = r_addr;

`ifdef MEM_READ_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] r_grants [NUM_REQ];
  logic [STAT_WIDTH-1:0] r_wait_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_grants[i] <= '0;
      r_wait_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i]) r_grants[i] <= sat_inc(r_grants[i]);
      end
      if (r_state == S_WAIT) r_wait_cycles <= sat_inc(r_wait_cycles);
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_grants[g*STAT_WIDTH +: STAT_WIDTH] = r_grants[g];
  end
  assign stat_wait_cycles = r_wait_cycles;
`endif

`ifndef SYNTHESIS
  // A memory response is only legal while a read is outstanding.
  a_rsp_in_flight: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rsp_valid |-> (r_state == S_REQ || r_state == S_WAIT));
`endif

endmodule
